// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU cycle sequencer: state encoding,
// the HALT opcode and the limits of the memory read latencies.
package cpu_pkg;

    // Debug-visible state encoding; values are part of the external interface.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_COMMIT = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // Instruction word the ControlUnit decodes as HALT.
    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

    // Supported ROM/RAM read latencies and the down-counter width covering them.
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    localparam int LAT_W   = 2;

    // Preload value for the latency down-counter: a latency of N cycles
    // counts N-1 .. 0. Out-of-range latencies are clamped to the legal range.
    function automatic logic [LAT_W-1:0] lat_preload(input int lat);
        int clamped;
        clamped = lat;
        if (clamped < LAT_MIN) clamped = LAT_MIN;
        if (clamped > LAT_MAX) clamped = LAT_MAX;
        return LAT_W'(clamped - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        // NOTE: default assigned first so every path drives count_d (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, async active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments for state so all flops update together.
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle sequencer for the single-issue CPU datapath. Walks one
// instruction through FETCH/DECODE/EXEC/MEM/WB/COMMIT, absorbs ROM/RAM read
// latency, and provides run/step/halt control plus performance counters.
// All strobes are decoded from the current state only, so an asynchronous
// reset drops them in the same cycle.
module cpu_cycle_sequencer
    import cpu_pkg::*;
#(
    parameter int ROM_LATENCY = 1,
    parameter int RAM_LATENCY = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 step,
    input  logic                 halt_req,
    input  logic                 cu_mem_read,
    input  logic                 cu_mem_write,
    input  logic                 cu_reg_write,
    input  logic                 cu_halt,
    output logic                 pc_enable,
    output logic                 ir_load,
    output logic                 rf_we,
    output logic                 ram_rden,
    output logic                 ram_wren,
    output logic                 busy,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam logic [LAT_W-1:0] ROM_PRE = lat_preload(ROM_LATENCY);
    localparam logic [LAT_W-1:0] RAM_PRE = lat_preload(RAM_LATENCY);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             reg_write_q, reg_write_d;
    logic             halt_q, halt_d;
    logic             one_shot_q, one_shot_d;

    // Next-state, latency counter, decoded flags and per-state strobes.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        reg_write_d = reg_write_q;
        halt_d      = halt_q;
        one_shot_d  = one_shot_q;
        pc_enable   = 1'b0;
        ir_load     = 1'b0;
        rf_we       = 1'b0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // halt_req is deliberately ignored while stopped.
                if (run) begin
                    state_d    = ST_FETCH;
                    lat_d      = ROM_PRE;
                    one_shot_d = 1'b0;
                end else if (step) begin
                    state_d    = ST_FETCH;
                    lat_d      = ROM_PRE;
                    one_shot_d = 1'b1;
                end
            end
            ST_FETCH: begin
                if (lat_q == '0) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_DECODE: begin
                // Snapshot ControlUnit outputs; later states use only these.
                mem_read_d  = cu_mem_read;
                mem_write_d = cu_mem_write;
                reg_write_d = cu_reg_write;
                halt_d      = cu_halt;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                if (mem_read_q) begin
                    state_d = ST_MEM;
                    lat_d   = RAM_PRE;
                end else if (mem_write_q) begin
                    state_d = ST_MEM;
                end else if (reg_write_q) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_MEM: begin
                // A read wins over a simultaneous write: treated as a load.
                if (mem_read_q) begin
                    ram_rden = 1'b1;
                    if (lat_q == '0) begin
                        state_d = ST_WB;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end else begin
                    ram_wren = 1'b1;
                    state_d  = ST_COMMIT;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                pc_enable = 1'b1;
                if (halt_q || halt_req) begin
                    state_d    = ST_HALT;
                    one_shot_d = 1'b0;
                end else if (one_shot_q) begin
                    state_d    = ST_HALT;
                    one_shot_d = 1'b0;
                end else if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                    lat_d   = ROM_PRE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latency counter and instruction flags, async active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            halt_q      <= 1'b0;
            one_shot_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            halt_q      <= halt_d;
            one_shot_q  <= one_shot_d;
        end
    end

    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted = (state_q == ST_HALT);
    assign state  = state_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (busy),
        .clear   (1'b0),
        .count   (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_retired_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (state_q == ST_COMMIT),
        .clear   (1'b0),
        .count   (retired_count)
    );

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed bench for cpu_cycle_sequencer. The main instance uses
// RAM_LATENCY=2; a second instance with 3-bit counters shares the inputs
// to observe counter saturation.
module tb_cpu_cycle_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset_n, run, step, halt_req;
    logic cu_mem_read, cu_mem_write, cu_reg_write, cu_halt;

    logic        pc_enable, ir_load, rf_we, ram_rden, ram_wren, busy, halted;
    logic [2:0]  state;
    logic [31:0] cycle_count, retired_count;

    logic        s_pc_enable, s_ir_load, s_rf_we, s_ram_rden, s_ram_wren, s_busy, s_halted;
    logic [2:0]  s_state;
    logic [2:0]  s_cycle_count, s_retired_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_cycle_sequencer #(.ROM_LATENCY(1), .RAM_LATENCY(2), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .halt_req(halt_req),
        .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write),
        .cu_reg_write(cu_reg_write), .cu_halt(cu_halt),
        .pc_enable(pc_enable), .ir_load(ir_load), .rf_we(rf_we),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .busy(busy), .halted(halted),
        .state(state), .cycle_count(cycle_count), .retired_count(retired_count)
    );

    cpu_cycle_sequencer #(.ROM_LATENCY(1), .RAM_LATENCY(2), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .halt_req(halt_req),
        .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write),
        .cu_reg_write(cu_reg_write), .cu_halt(cu_halt),
        .pc_enable(s_pc_enable), .ir_load(s_ir_load), .rf_we(s_rf_we),
        .ram_rden(s_ram_rden), .ram_wren(s_ram_wren), .busy(s_busy), .halted(s_halted),
        .state(s_state), .cycle_count(s_cycle_count), .retired_count(s_retired_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle, then check state and {pc_enable, ir_load, rf_we, ram_rden, ram_wren}.
    task automatic cyc(input string tag, input state_e st, input logic [4:0] strobes);
        tick();
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_strb"}, 32'({pc_enable, ir_load, rf_we, ram_rden, ram_wren}), 32'(strobes));
    endtask

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_PC   = 5'b10000;
    localparam logic [4:0] S_IR   = 5'b01000;
    localparam logic [4:0] S_WE   = 5'b00100;
    localparam logic [4:0] S_RD   = 5'b00010;
    localparam logic [4:0] S_WR   = 5'b00001;

    // Watchdog: every wait above is a fixed cycle count, this only guards a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        cu_mem_read = 1'b0; cu_mem_write = 1'b0; cu_reg_write = 1'b0; cu_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",   32'(state), 32'(ST_IDLE));
        check("rst_strb",    32'({pc_enable, ir_load, rf_we, ram_rden, ram_wren}), 32'(S_NONE));
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_halted",  32'(halted), 32'd0);
        check("rst_cycles",  cycle_count, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        reset_n = 1'b1;

        // ALU op: ir_load cycle 1, rf_we cycle 4, pc_enable cycle 5, next ir_load cycle 6.
        run = 1'b1; cu_reg_write = 1'b1;
        cyc("alu_f", ST_FETCH,  S_IR);
        cyc("alu_d", ST_DECODE, S_NONE);
        cyc("alu_e", ST_EXEC,   S_NONE);
        cyc("alu_w", ST_WB,     S_WE);
        cyc("alu_c", ST_COMMIT, S_PC);
        cu_mem_read = 1'b1;
        cyc("ld_f", ST_FETCH, S_IR);
        check("alu_retired", retired_count, 32'd1);
        check("alu_cycles",  cycle_count, 32'd5);
        check("alu_sat_cyc", 32'(s_cycle_count), 32'd5);
        check("alu_sat_ret", 32'(s_retired_count), 32'd1);

        // Load, RAM_LATENCY=2: 7 cycles, rden exactly 2 cycles, then rf_we, then pc_enable.
        cyc("ld_d",  ST_DECODE, S_NONE);
        cyc("ld_e",  ST_EXEC,   S_NONE);
        cyc("ld_m1", ST_MEM,    S_RD);
        cyc("ld_m2", ST_MEM,    S_RD);
        cyc("ld_w",  ST_WB,     S_WE);
        cyc("ld_c",  ST_COMMIT, S_PC);
        cu_mem_read = 1'b0; cu_mem_write = 1'b1; cu_reg_write = 1'b0;
        cyc("st_f", ST_FETCH, S_IR);
        check("ld_retired", retired_count, 32'd2);
        check("ld_cycles",  cycle_count, 32'd12);
        check("ld_sat_cyc", 32'(s_cycle_count), 32'd7);

        // Store: single wren pulse, no WB, pc_enable next; run dropped -> IDLE.
        cyc("st_d", ST_DECODE, S_NONE);
        cyc("st_e", ST_EXEC,   S_NONE);
        cyc("st_m", ST_MEM,    S_WR);
        run = 1'b0;
        cyc("st_c", ST_COMMIT, S_PC);
        cyc("st_idle", ST_IDLE, S_NONE);
        check("st_busy",    32'(busy), 32'd0);
        check("st_retired", retired_count, 32'd3);
        check("st_cycles",  cycle_count, 32'd17);

        // Single step of a branch (no mem, no reg write): 4 cycles then HALT.
        cu_mem_write = 1'b0;
        step = 1'b1;
        cyc("s1_f", ST_FETCH, S_IR);
        step = 1'b0;
        cyc("s1_d", ST_DECODE, S_NONE);
        cyc("s1_e", ST_EXEC,   S_NONE);
        cyc("s1_c", ST_COMMIT, S_PC);
        cyc("s1_h", ST_HALT,   S_NONE);
        check("s1_halted",  32'(halted), 32'd1);
        check("s1_busy",    32'(busy), 32'd0);
        check("s1_retired", retired_count, 32'd4);
        cyc("s1_h2", ST_HALT, S_NONE);
        check("s1_frozen",  cycle_count, 32'd21);

        // Second step with read and write both set: behaves as a load, no wren.
        cu_mem_read = 1'b1; cu_mem_write = 1'b1; cu_reg_write = 1'b1;
        step = 1'b1;
        cyc("s2_f", ST_FETCH, S_IR);
        step = 1'b0;
        cyc("s2_d",  ST_DECODE, S_NONE);
        cyc("s2_e",  ST_EXEC,   S_NONE);
        cyc("s2_m1", ST_MEM,    S_RD);
        cyc("s2_m2", ST_MEM,    S_RD);
        cyc("s2_w",  ST_WB,     S_WE);
        cyc("s2_c",  ST_COMMIT, S_PC);
        cyc("s2_h",  ST_HALT,   S_NONE);
        check("s2_retired", retired_count, 32'd5);
        check("s2_cycles",  cycle_count, 32'd28);

        // run and step together: free-running; a step pulse while busy is ignored.
        cu_mem_read = 1'b0; cu_mem_write = 1'b0;
        run = 1'b1; step = 1'b1;
        cyc("rs_f", ST_FETCH, S_IR);
        step = 1'b0;
        cyc("rs_d", ST_DECODE, S_NONE);
        cyc("rs_e", ST_EXEC,   S_NONE);
        step = 1'b1;
        cyc("rs_w", ST_WB,     S_WE);
        step = 1'b0;
        cyc("rs_c", ST_COMMIT, S_PC);
        cyc("rs_f2", ST_FETCH, S_IR);
        check("rs_retired", retired_count, 32'd6);
        check("rs_cycles",  cycle_count, 32'd33);

        // halt_req raised in EXEC: instruction completes, then HALT (not IDLE).
        cu_reg_write = 1'b0;
        cyc("hr_d", ST_DECODE, S_NONE);
        cyc("hr_e", ST_EXEC,   S_NONE);
        halt_req = 1'b1; run = 1'b0;
        cyc("hr_c", ST_COMMIT, S_PC);
        cyc("hr_h", ST_HALT,   S_NONE);
        check("hr_halted",  32'(halted), 32'd1);
        check("hr_retired", retired_count, 32'd7);
        halt_req = 1'b0;
        cyc("hr_h2", ST_HALT, S_NONE);
        check("hr_frozen", cycle_count, 32'd37);

        // cu_halt instruction: HALT after its COMMIT even with run low.
        run = 1'b1; cu_halt = 1'b1;
        cyc("ch_f", ST_FETCH,  S_IR);
        cyc("ch_d", ST_DECODE, S_NONE);
        cyc("ch_e", ST_EXEC,   S_NONE);
        run = 1'b0;
        cyc("ch_c", ST_COMMIT, S_PC);
        cyc("ch_h", ST_HALT,   S_NONE);
        check("ch_retired", retired_count, 32'd8);
        check("ch_cycles",  cycle_count, 32'd41);
        check("sat_cycles",  32'(s_cycle_count), 32'd7);
        check("sat_retired", 32'(s_retired_count), 32'd7);
        cu_halt = 1'b0;

        // Reset during a store's MEM cycle drops wren asynchronously.
        run = 1'b1; cu_mem_write = 1'b1;
        cyc("rm_f", ST_FETCH,  S_IR);
        cyc("rm_d", ST_DECODE, S_NONE);
        cyc("rm_e", ST_EXEC,   S_NONE);
        cyc("rm_m", ST_MEM,    S_WR);
        #2;
        reset_n = 1'b0;
        #1;
        check("rm_wren",    32'(ram_wren), 32'd0);
        check("rm_state",   32'(state), 32'(ST_IDLE));
        check("rm_cycles",  cycle_count, 32'd0);
        check("rm_retired", retired_count, 32'd0);
        check("rm_busy",    32'(busy), 32'd0);
        run = 1'b0;
        cyc("rm_hold", ST_IDLE, S_NONE);
        check("rm_hold_cycles", cycle_count, 32'd0);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
